// File: rtl/counter_4b.sv
// counter_4b: binary up/down counter with synchronous clear, parallel load,
// count enable, optional saturation, a combinational terminal-count flag and
// a registered one-cycle wrap pulse.
module counter_4b #(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] RST_VAL  = '0,
   parameter bit               SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_wrap_nxt;
   logic             w_at_max;
   logic             w_at_min;

   // One enabled step: returns {wrap, next_count}. At a limit the counter
   // either rolls over (flagging wrap) or holds when saturating.
   function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] cur,
                                                 input logic             dir_up);
      logic [WIDTH-1:0] nxt;
      logic             wr;
      nxt = cur;
      wr  = 1'b0;
      if (dir_up) begin
         if (cur == ALL_ONES) begin
            if (SATURATE) begin
               nxt = cur;
            end else begin
               nxt = ZERO;
               wr  = 1'b1;
            end
         end else begin
            nxt = cur + 1'b1;
         end
      end else begin
         if (cur == ZERO) begin
            if (SATURATE) begin
               nxt = cur;
            end else begin
               nxt = ALL_ONES;
               wr  = 1'b1;
            end
         end else begin
            nxt = cur - 1'b1;
         end
      end
      return {wr, nxt};
   endfunction

   assign w_at_max = (r_count == ALL_ONES);
   assign w_at_min = (r_count == ZERO);

   // Next-state selection with priority clr > load > en; wrap only from a step.
   always_comb begin
      w_count_nxt = r_count;
      w_wrap_nxt  = 1'b0;
      if (clr) begin
         w_count_nxt = RST_VAL;
      end else if (load) begin
         w_count_nxt = load_val;
      end else if (en) begin
         {w_wrap_nxt, w_count_nxt} = step_count(r_count, up_dn);
      end
   end

   // State register; synchronous reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= RST_VAL;
         r_wrap  <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_wrap  <= w_wrap_nxt;
      end
   end

   assign count = r_count;
   assign wrap  = r_wrap;
   assign tc    = (up_dn && w_at_max) || (!up_dn && w_at_min);

endmodule

// File: tb/tb_counter_4b.sv
// Directed testbench for counter_4b: a wrapping instance and a saturating
// instance share the same stimulus.
module tb_counter_4b;

   logic       clk;
   logic       rst;
   logic       en;
   logic       up_dn;
   logic       clr;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] count;
   logic       tc;
   logic       wrap;
   logic [3:0] s_count;
   logic       s_tc;
   logic       s_wrap;

   int checks = 0;
   int errors = 0;

   counter_4b #(.WIDTH(4), .RST_VAL(4'd0), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
   );

   counter_4b #(.WIDTH(4), .RST_VAL(4'd0), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .count(s_count), .tc(s_tc), .wrap(s_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up_dn = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;

      // Reset
      tick();
      check("rst_count", 32'(count), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      check("rst_tc_down", 32'(tc), 32'd1);
      check("rst_sat_count", 32'(s_count), 32'd0);

      // Count up after release
      rst = 1'b0; en = 1'b1; up_dn = 1'b1;
      #1;
      check("tc_up_at0", 32'(tc), 32'd0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         check("up_count", 32'(count), 32'(i));
      end

      // Wrap up from 0 over 16 edges
      clr = 1'b1;
      tick();
      check("clr_count", 32'(count), 32'd0);
      clr = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         check("wrapup_count", 32'(count), 32'(i % 16));
         check("wrapup_wrap", 32'(wrap), (i == 16) ? 32'd1 : 32'd0);
         check("wrapup_tc", 32'(tc), (i == 15) ? 32'd1 : 32'd0);
         check("sat_nowrap", 32'(s_wrap), 32'd0);
      end
      tick();
      check("wrap_pulse_end", 32'(wrap), 32'd0);
      check("after_wrap_count", 32'(count), 32'd1);

      // Down through zero
      en = 1'b0; load = 1'b1; load_val = 4'd2;
      tick();
      check("load2", 32'(count), 32'd2);
      load = 1'b0; up_dn = 1'b0; en = 1'b1;
      tick();
      check("down1", 32'(count), 32'd1);
      tick();
      check("down0", 32'(count), 32'd0);
      check("down_tc0", 32'(tc), 32'd1);
      check("down_wrap_pre", 32'(wrap), 32'd0);
      tick();
      check("down15", 32'(count), 32'd15);
      check("down_wrap", 32'(wrap), 32'd1);
      check("down_tc15", 32'(tc), 32'd0);
      tick();
      check("down14", 32'(count), 32'd14);
      check("down_wrap_end", 32'(wrap), 32'd0);

      // Priority: clr beats load and en
      load = 1'b1; load_val = 4'd9; clr = 1'b1; en = 1'b1;
      tick();
      check("prio_clr", 32'(count), 32'd0);
      clr = 1'b0; en = 1'b0;
      tick();
      check("prio_load", 32'(count), 32'd9);

      // Hold
      load_val = 4'd7;
      tick();
      load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_count", 32'(count), 32'd7);
         check("hold_wrap", 32'(wrap), 32'd0);
      end

      // Load all-ones gives no wrap; next up step wraps
      up_dn = 1'b1; load = 1'b1; load_val = 4'd15;
      tick();
      check("load15_count", 32'(count), 32'd15);
      check("load15_wrap", 32'(wrap), 32'd0);
      check("load15_tc", 32'(tc), 32'd1);
      load = 1'b0; en = 1'b1;
      tick();
      check("load15_step", 32'(count), 32'd0);
      check("load15_step_wrap", 32'(wrap), 32'd1);

      // Saturate up from 13
      en = 1'b0; load = 1'b1; load_val = 4'd13;
      tick();
      load = 1'b0; en = 1'b1; up_dn = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         check("sat_up_count", 32'(s_count), (i == 1) ? 32'd14 : 32'd15);
         check("sat_up_wrap", 32'(s_wrap), 32'd0);
      end
      check("sat_tc", 32'(s_tc), 32'd1);

      // Saturate down to 0
      en = 1'b0; load = 1'b1; load_val = 4'd1;
      tick();
      load = 1'b0; en = 1'b1; up_dn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("sat_dn_count", 32'(s_count), 32'd0);
         check("sat_dn_wrap", 32'(s_wrap), 32'd0);
      end

      // Reset mid-count
      up_dn = 1'b1; load = 1'b1; load_val = 4'd5;
      tick();
      load = 1'b0; rst = 1'b1;
      tick();
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_wrap", 32'(wrap), 32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_count", 32'(count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
